// File: rtl/aurora_tx_packetizer_pkg.sv
// Shared definitions for the Aurora TX packetizer: register map, ctrl/status
// bit positions, FSM state encoding and a small saturation helper.
package aurora_tx_packetizer_pkg;

    // Programmed-I/O register map
    localparam logic [15:0] ADDR_PUSH      = 16'h0020;
    localparam logic [15:0] ADDR_PUSH_LAST = 16'h0021;
    localparam logic [15:0] ADDR_CTRL      = 16'h0022;
    localparam logic [15:0] ADDR_STATUS    = 16'h0023;
    localparam logic [15:0] ADDR_FRAMES    = 16'h0024;
    localparam logic [15:0] ADDR_STALL     = 16'h0025;

    // Control register bits
    localparam int CTRL_ENABLE_BIT  = 0;
    localparam int CTRL_FLUSH_BIT   = 1;
    localparam int CTRL_CLR_OVF_BIT = 2;

    // Status register layout
    localparam int ST_FILL_LSB = 0;
    localparam int ST_PEND_LSB = 8;
    localparam int ST_OVF_BIT  = 16;
    localparam int ST_CHUP_BIT = 17;
    localparam int ST_BUSY_BIT = 18;
    localparam int ST_EN_BIT   = 19;

    localparam logic [3:0] TKEEP_ALL = 4'b1111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_t;

    // Clamp a count into an 8-bit status field (a 256-deep FIFO can hold 256)
    function automatic logic [7:0] sat8(input logic [31:0] v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/aurora_tx_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with first-word-fall-through head, used as
// the store-and-forward frame buffer. Flush empties it in one cycle.
module aurora_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 33
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_fill
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_fill;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_fill == (AW+1)'(DEPTH));
    assign o_empty   = (r_fill == '0);
    assign o_fill    = r_fill;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full & ~i_flush;
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;

    // Storage array; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy tracking; flush discards everything at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

endmodule

// File: rtl/aurora_tx_packetizer.sv
// Aurora TX packetizer: programmed-I/O words are buffered store-and-forward
// and launched as AXI-stream frames once a complete frame is in the FIFO.
// Optional feature macro: AURORA_TX_STALL_CNT_EN adds a 16-bit saturating
// count of tvalid & !tready cycles at address 0x0025 (reads 0 otherwise).
module aurora_tx_packetizer
    import aurora_tx_packetizer_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int MAX_LEN = 8
) (
    input  logic        io_clk,
    input  logic        reset_n,
    input  logic        io_sel,
    input  logic        io_sync,
    input  logic [15:0] io_addr,
    input  logic        io_rd_en,
    input  logic        io_wr_en,
    input  logic [31:0] io_wr_data,
    output logic [31:0] io_rd_data,
    output logic        io_rd_ack,
    input  logic        channel_up,
    output logic [31:0] tx_data,
    output logic        tx_tvalid,
    input  logic        tx_tready,
    output logic [3:0]  tx_tkeep,
    output logic        tx_tlast
);
    localparam int FILL_W = $clog2(DEPTH) + 1;
    localparam int WCNT_W = (MAX_LEN > 1) ? $clog2(MAX_LEN + 1) : 1;

    tx_state_t         r_state;
    logic              r_tvalid;
    logic [31:0]       r_frames_sent;
    logic              r_enable;
    logic              r_flush_pend;
    logic              r_overflow;
    logic [WCNT_W-1:0] r_word_cnt;
    logic [FILL_W-1:0] r_pend;
    logic [31:0]       r_rd_data;
    logic              r_rd_ack;

    logic              w_wr_strobe;
    logic              w_push_req;
    logic              w_push_ok;
    logic              w_push_drop;
    logic              w_push_last;
    logic              w_ctrl_wr;
    logic              w_flush_exec;
    logic              w_pop;
    logic              w_pop_last;
    logic [32:0]       w_head;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [FILL_W-1:0] w_fill;
    logic [31:0]       w_status;
    logic [31:0]       w_ctrl_rd;
    logic [31:0]       w_stall_rd;
    logic [31:0]       w_rd_mux;

    assign w_wr_strobe  = io_sel & io_wr_en;
    assign w_push_req   = w_wr_strobe & ((io_addr == ADDR_PUSH) | (io_addr == ADDR_PUSH_LAST));
    // Fullness is judged on the registered fill, so a same-cycle pop never rescues a push
    assign w_push_ok    = w_push_req & ~w_fifo_full;
    assign w_push_drop  = w_push_req & w_fifo_full;
    assign w_push_last  = (io_addr == ADDR_PUSH_LAST) | (r_word_cnt == WCNT_W'(MAX_LEN - 1));
    assign w_ctrl_wr    = w_wr_strobe & (io_addr == ADDR_CTRL);
    // Flush waits for IDLE so a frame already on the wire is never cut short
    assign w_flush_exec = (r_state == ST_IDLE) & r_flush_pend;
    assign w_pop        = r_tvalid & tx_tready & ~w_fifo_empty;
    assign w_pop_last   = w_pop & w_head[32];

    aurora_tx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (33)
    ) u_fifo (
        .clk         (io_clk),
        .rst_n       (reset_n),
        .i_push      (w_push_ok),
        .i_push_data ({w_push_last, io_wr_data}),
        .i_pop       (w_pop),
        .i_flush     (w_flush_exec),
        .o_head      (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_fill      (w_fill)
    );

    // Head of FIFO drives the stream; forced to zero whenever no beat is offered
    assign tx_tvalid = r_tvalid;
    assign tx_data   = r_tvalid ? w_head[31:0] : 32'd0;
    assign tx_tlast  = r_tvalid & w_head[32];
    assign tx_tkeep  = TKEEP_ALL;

    // Control register: enable, latched flush request, sticky overflow
    always_ff @(posedge io_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_enable     <= 1'b0;
            r_flush_pend <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_enable <= io_wr_data[CTRL_ENABLE_BIT];
            if (w_ctrl_wr && io_wr_data[CTRL_FLUSH_BIT]) r_flush_pend <= 1'b1;
            else if (w_flush_exec)                        r_flush_pend <= 1'b0;
            if (w_ctrl_wr && io_wr_data[CTRL_CLR_OVF_BIT]) r_overflow <= 1'b0;
            else if (w_push_drop)                          r_overflow <= 1'b1;
        end
    end

    // Write-side framing: count accepted words and force a last at MAX_LEN
    always_ff @(posedge io_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_word_cnt <= '0;
        end else if (w_flush_exec) begin
            r_word_cnt <= '0;
        end else if (w_push_ok) begin
            r_word_cnt <= w_push_last ? '0 : r_word_cnt + 1'b1;
        end
    end

    // Complete-frame counter: one per last word held in the FIFO
    always_ff @(posedge io_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend <= '0;
        end else if (w_flush_exec) begin
            r_pend <= '0;
        end else begin
            case ({w_push_ok & w_push_last, w_pop_last})
                2'b10:   r_pend <= r_pend + 1'b1;
                2'b01:   r_pend <= r_pend - 1'b1;
                default: r_pend <= r_pend;
            endcase
        end
    end

    // Frame launch FSM; once in SEND the frame always runs to its last beat
    always_ff @(posedge io_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_tvalid      <= 1'b0;
            r_frames_sent <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_flush_pend && r_enable && channel_up && (r_pend != '0)) begin
                        r_state  <= ST_SEND;
                        r_tvalid <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (w_pop_last) begin
                        r_state       <= ST_IDLE;
                        r_tvalid      <= 1'b0;
                        r_frames_sent <= r_frames_sent + 32'd1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_tvalid <= 1'b0;
                end
            endcase
        end
    end

`ifdef AURORA_TX_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of cycles where a beat is offered but not taken
    always_ff @(posedge io_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= 16'd0;
        end else if (w_ctrl_wr && io_wr_data[CTRL_CLR_OVF_BIT]) begin
            r_stall_cnt <= 16'd0;
        end else if (r_tvalid && !tx_tready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign w_stall_rd = {16'd0, r_stall_cnt};
`else
    assign w_stall_rd = 32'd0;
`endif

    // Status and ctrl readback images
    always_comb begin
        w_status = 32'd0;
        w_status[ST_FILL_LSB +: 8] = sat8(32'(w_fill));
        w_status[ST_PEND_LSB +: 8] = sat8(32'(r_pend));
        w_status[ST_OVF_BIT]       = r_overflow;
        w_status[ST_CHUP_BIT]      = channel_up;
        w_status[ST_BUSY_BIT]      = (r_state == ST_SEND);
        w_status[ST_EN_BIT]        = r_enable;
        w_ctrl_rd = 32'd0;
        w_ctrl_rd[CTRL_ENABLE_BIT] = r_enable;
        w_ctrl_rd[CTRL_FLUSH_BIT]  = r_flush_pend;
    end

    // Read address decode; push addresses are write-only and read as zero
    always_comb begin
        w_rd_mux = 32'd0;
        case (io_addr)
            ADDR_CTRL:   w_rd_mux = w_ctrl_rd;
            ADDR_STATUS: w_rd_mux = w_status;
            ADDR_FRAMES: w_rd_mux = r_frames_sent;
            ADDR_STALL:  w_rd_mux = w_stall_rd;
            default:     w_rd_mux = 32'd0;
        endcase
    end

    // Registered read port with one-cycle acknowledge
    always_ff @(posedge io_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ack  <= 1'b0;
            r_rd_data <= 32'd0;
        end else begin
            r_rd_ack <= io_sync & io_sel & io_rd_en;
            if (io_sync && io_sel && io_rd_en) r_rd_data <= w_rd_mux;
        end
    end

    assign io_rd_ack  = r_rd_ack;
    assign io_rd_data = r_rd_data;

endmodule

// File: tb/tb_aurora_tx_packetizer.sv
// Directed testbench for aurora_tx_packetizer (DEPTH=16, MAX_LEN=8).
module tb_aurora_tx_packetizer;

`ifdef AURORA_TX_STALL_CNT_EN
    localparam logic [31:0] EXP_STALL = 32'd5;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    logic        io_clk = 1'b0;
    logic        reset_n;
    logic        io_sel;
    logic        io_sync;
    logic [15:0] io_addr;
    logic        io_rd_en;
    logic        io_wr_en;
    logic [31:0] io_wr_data;
    logic [31:0] io_rd_data;
    logic        io_rd_ack;
    logic        channel_up;
    logic [31:0] tx_data;
    logic        tx_tvalid;
    logic        tx_tready;
    logic [3:0]  tx_tkeep;
    logic        tx_tlast;

    aurora_tx_packetizer #(.DEPTH(16), .MAX_LEN(8)) dut (
        .io_clk     (io_clk),
        .reset_n    (reset_n),
        .io_sel     (io_sel),
        .io_sync    (io_sync),
        .io_addr    (io_addr),
        .io_rd_en   (io_rd_en),
        .io_wr_en   (io_wr_en),
        .io_wr_data (io_wr_data),
        .io_rd_data (io_rd_data),
        .io_rd_ack  (io_rd_ack),
        .channel_up (channel_up),
        .tx_data    (tx_data),
        .tx_tvalid  (tx_tvalid),
        .tx_tready  (tx_tready),
        .tx_tkeep   (tx_tkeep),
        .tx_tlast   (tx_tlast)
    );

    always #5 io_clk = ~io_clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] q_data[$];
    logic        q_last[$];
    int          q_cyc[$];

    always @(posedge io_clk) cyc <= cyc + 1;

    // Record every beat that will handshake at the coming rising edge
    always @(negedge io_clk) begin
        if (reset_n && tx_tvalid && tx_tready) begin
            q_data.push_back(tx_data);
            q_last.push_back(tx_tlast);
            q_cyc.push_back(cyc);
        end
    end

    typedef struct {
        logic [15:0] addr;
        logic [31:0] exp;
    } rd_vec_t;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        logic        exp_last;
    } beat_vec_t;

    rd_vec_t   rst_tab[7];
    beat_vec_t t1_tab[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic io_write(input logic [15:0] a, input logic [31:0] d);
        @(posedge io_clk); #1;
        io_sel = 1'b1; io_wr_en = 1'b1; io_addr = a; io_wr_data = d;
        @(posedge io_clk); #1;
        io_sel = 1'b0; io_wr_en = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [15:0] a, input logic [31:0] exp);
        @(posedge io_clk); #1;
        io_sel = 1'b1; io_sync = 1'b1; io_rd_en = 1'b1; io_addr = a;
        @(posedge io_clk); #1;
        io_sel = 1'b0; io_sync = 1'b0; io_rd_en = 1'b0;
        check({name, "_ack"}, 32'(io_rd_ack), 32'd1);
        check(name, io_rd_data, exp);
    endtask

    task automatic clear_q();
        q_data.delete();
        q_last.delete();
        q_cyc.delete();
    endtask

    // Wait (bounded) for n beats, then let the stream settle and check the count
    task automatic wait_beats(input string name, input int n, input int budget, input int settle);
        for (int i = 0; i < budget && q_data.size() < n; i++) @(posedge io_clk);
        repeat (settle) @(posedge io_clk);
        #1;
        check(name, 32'(q_data.size()), 32'(n));
    endtask

    task automatic wait_tvalid(input string name);
        for (int i = 0; i < 20 && !tx_tvalid; i++) @(negedge io_clk);
        check(name, 32'(tx_tvalid), 32'd1);
    endtask

    task automatic run_reset_table(input string tag);
        for (int i = 0; i < 7; i++) begin
            read_check($sformatf("%s_rd_%04h", tag, rst_tab[i].addr), rst_tab[i].addr, rst_tab[i].exp);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_tab[0] = '{16'h0020, 32'h0000_0000};
        rst_tab[1] = '{16'h0021, 32'h0000_0000};
        rst_tab[2] = '{16'h0022, 32'h0000_0000};
        rst_tab[3] = '{16'h0023, 32'h0002_0000};
        rst_tab[4] = '{16'h0024, 32'h0000_0000};
        rst_tab[5] = '{16'h0025, 32'h0000_0000};
        rst_tab[6] = '{16'h0030, 32'h0000_0000};
        t1_tab[0]  = '{16'h0020, 32'h0000_0011, 1'b0};
        t1_tab[1]  = '{16'h0020, 32'h0000_0022, 1'b0};
        t1_tab[2]  = '{16'h0021, 32'h0000_0033, 1'b1};

        reset_n = 1'b0; io_sel = 1'b0; io_sync = 1'b0; io_addr = 16'h0;
        io_rd_en = 1'b0; io_wr_en = 1'b0; io_wr_data = 32'h0;
        channel_up = 1'b1; tx_tready = 1'b1;
        repeat (3) @(posedge io_clk);
        #1;
        check("rst_tvalid", 32'(tx_tvalid), 32'd0);
        check("rst_tlast", 32'(tx_tlast), 32'd0);
        check("rst_tdata", tx_data, 32'd0);
        check("rst_rd_ack", 32'(io_rd_ack), 32'd0);
        check("rst_rd_data", io_rd_data, 32'd0);
        reset_n = 1'b1;
        check("tkeep", 32'(tx_tkeep), 32'hF);
        run_reset_table("reset");

        // 1: three-word frame, back-to-back beats
        for (int i = 0; i < 3; i++) io_write(t1_tab[i].addr, t1_tab[i].data);
        read_check("t1_status_pre", 16'h0023, 32'h0002_0103);
        clear_q();
        io_write(16'h0022, 32'h1);
        wait_beats("t1_beats", 3, 30, 5);
        for (int i = 0; i < 3 && i < q_data.size(); i++) begin
            check($sformatf("t1_data%0d", i), q_data[i], t1_tab[i].data);
            check($sformatf("t1_last%0d", i), 32'(q_last[i]), 32'(t1_tab[i].exp_last));
        end
        if (q_cyc.size() == 3) check("t1_back2back", 32'(q_cyc[2] - q_cyc[0]), 32'd2);
        read_check("t1_frames", 16'h0024, 32'd1);
        read_check("t1_status_post", 16'h0023, 32'h000A_0000);

        // 2: back-pressure for 5 cycles after the first beat
        io_write(16'h0022, 32'h4);
        io_write(16'h0020, 32'h11);
        io_write(16'h0020, 32'h22);
        io_write(16'h0021, 32'h33);
        clear_q();
        io_write(16'h0022, 32'h1);
        wait_tvalid("t2_first_valid");
        check("t2_first_data", tx_data, 32'h11);
        @(posedge io_clk); #1;
        tx_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge io_clk);
            check($sformatf("t2_hold_valid%0d", i), 32'(tx_tvalid), 32'd1);
            check($sformatf("t2_hold_data%0d", i), tx_data, 32'h22);
            @(posedge io_clk); #1;
        end
        tx_tready = 1'b1;
        wait_beats("t2_beats", 3, 30, 5);
        if (q_data.size() == 3) begin
            check("t2_data1", q_data[1], 32'h22);
            check("t2_data2", q_data[2], 32'h33);
            check("t2_last2", 32'(q_last[2]), 32'd1);
            check("t2_gap", 32'(q_cyc[1] - q_cyc[0]), 32'd6);
        end
        read_check("t2_stall", 16'h0025, EXP_STALL);
        read_check("t2_frames", 16'h0024, 32'd2);

        // 3: overflow with DEPTH=16, then drain to show the 17th word was lost
        io_write(16'h0022, 32'h0);
        for (int i = 1; i <= 17; i++) io_write(16'h0020, 32'(i));
        read_check("t3_status_ovf", 16'h0023, 32'h0003_0210);
        io_write(16'h0022, 32'h4);
        read_check("t3_status_clr", 16'h0023, 32'h0002_0210);
        clear_q();
        io_write(16'h0022, 32'h1);
        wait_beats("t3_beats", 16, 80, 5);
        if (q_data.size() == 16) begin
            check("t3_last7", 32'(q_last[7]), 32'd1);
            check("t3_last6", 32'(q_last[6]), 32'd0);
            check("t3_data15", q_data[15], 32'd16);
            check("t3_last15", 32'(q_last[15]), 32'd1);
        end
        read_check("t3_status_post", 16'h0023, 32'h000A_0000);
        read_check("t3_frames", 16'h0024, 32'd4);

        // 4: nine words without last -> forced last on word 8, word 9 waits
        io_write(16'h0022, 32'h0);
        for (int i = 0; i < 9; i++) io_write(16'h0020, 32'h40 + 32'(i));
        read_check("t4_status_pre", 16'h0023, 32'h0002_0109);
        clear_q();
        io_write(16'h0022, 32'h1);
        wait_beats("t4_beats8", 8, 40, 8);
        check("t4_idle_valid", 32'(tx_tvalid), 32'd0);
        if (q_data.size() == 8) begin
            check("t4_data7", q_data[7], 32'h47);
            check("t4_last7", 32'(q_last[7]), 32'd1);
        end
        read_check("t4_status_mid", 16'h0023, 32'h000A_0001);
        io_write(16'h0021, 32'hAA);
        wait_beats("t4_beats10", 10, 30, 5);
        if (q_data.size() == 10) begin
            check("t4_data8", q_data[8], 32'h48);
            check("t4_last8", 32'(q_last[8]), 32'd0);
            check("t4_data9", q_data[9], 32'hAA);
            check("t4_last9", 32'(q_last[9]), 32'd1);
        end
        read_check("t4_frames", 16'h0024, 32'd6);

        // 5: incomplete frame waits; flush written during SEND applies after tlast
        clear_q();
        io_write(16'h0020, 32'h51);
        io_write(16'h0020, 32'h52);
        repeat (10) @(posedge io_clk);
        #1;
        check("t5_no_valid", 32'(tx_tvalid), 32'd0);
        check("t5_no_beats", 32'(q_data.size()), 32'd0);
        tx_tready = 1'b0;
        io_write(16'h0021, 32'h53);
        wait_tvalid("t5_valid");
        io_write(16'h0022, 32'h3);
        io_write(16'h0021, 32'h5F);
        read_check("t5_ctrl_pend", 16'h0022, 32'h3);
        @(posedge io_clk); #1;
        tx_tready = 1'b1;
        wait_beats("t5_beats", 3, 30, 10);
        if (q_data.size() == 3) begin
            check("t5_data0", q_data[0], 32'h51);
            check("t5_data2", q_data[2], 32'h53);
            check("t5_last2", 32'(q_last[2]), 32'd1);
        end
        read_check("t5_status", 16'h0023, 32'h000A_0000);
        read_check("t5_ctrl", 16'h0022, 32'h1);
        read_check("t5_frames", 16'h0024, 32'd7);

        // 6: asynchronous reset mid-frame, then a clean new frame
        io_write(16'h0022, 32'h0);
        io_write(16'h0020, 32'h61);
        io_write(16'h0020, 32'h62);
        io_write(16'h0021, 32'h63);
        tx_tready = 1'b0;
        io_write(16'h0022, 32'h1);
        wait_tvalid("t6_valid");
        @(posedge io_clk); #1;
        reset_n = 1'b0;
        #1;
        check("t6_async_tvalid", 32'(tx_tvalid), 32'd0);
        check("t6_async_tdata", tx_data, 32'd0);
        repeat (2) @(posedge io_clk);
        #1;
        reset_n = 1'b1;
        tx_tready = 1'b1;
        run_reset_table("t6");
        clear_q();
        io_write(16'h0020, 32'h71);
        io_write(16'h0021, 32'h72);
        io_write(16'h0022, 32'h1);
        wait_beats("t6_beats", 2, 30, 5);
        if (q_data.size() == 2) begin
            check("t6_data0", q_data[0], 32'h71);
            check("t6_data1", q_data[1], 32'h72);
            check("t6_last1", 32'(q_last[1]), 32'd1);
        end
        read_check("t6_frames", 16'h0024, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
